// File: rtl/lcd_cfah_bus_engine.sv
// HD44780-compatible register read/write engine for the CFAH1602 path, 8-bit or nibble bus per request.
// Optional build macro LCD_BUSY_POLL_EN: replace the fixed post-transfer wait with busy-flag polling on writes.
module lcd_cfah_bus_engine #(
    parameter int unsigned G_CLK_PERIOD_NS      = 20,
    parameter int unsigned G_T_AS_NS            = 60,
    parameter int unsigned G_T_PW_NS            = 460,
    parameter int unsigned G_T_H_NS             = 20,
    parameter int unsigned G_T_CYC_NS           = 1000,
    parameter int unsigned G_EXEC_WAIT_NS       = 40000,
    parameter int unsigned G_POLL_TIMEOUT       = 1024,
    parameter bit          G_BIDIR_SEL_POLARITY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic [7:0] i_wdata,
    input  logic       i_nibble,
    output logic       o_ready,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_timeout,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic [7:0] o_lcd_wdata,
    input  logic [7:0] i_lcd_data,
    output logic       o_bidir_sel
);

    function automatic int unsigned ns_to_cycles(input int unsigned ns);
        int unsigned c;
        c = (ns + G_CLK_PERIOD_NS - 1) / G_CLK_PERIOD_NS;
        return (c < 1) ? 1 : c;
    endfunction

    localparam int unsigned N_AS      = ns_to_cycles(G_T_AS_NS);
    localparam int unsigned N_PW      = ns_to_cycles(G_T_PW_NS);
    localparam int unsigned N_H       = ns_to_cycles(G_T_H_NS);
    localparam int unsigned N_CYC_RAW = ns_to_cycles(G_T_CYC_NS);
    localparam int unsigned N_CYC     = (N_CYC_RAW > N_AS + N_PW + N_H) ? N_CYC_RAW : N_AS + N_PW + N_H;
    localparam int unsigned N_EXEC    = ns_to_cycles(G_EXEC_WAIT_NS);
    localparam int unsigned CNT_MAX_A = (N_CYC > N_EXEC) ? N_CYC : N_EXEC;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > G_POLL_TIMEOUT) ? CNT_MAX_A : G_POLL_TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic        BIDIR_DRV = G_BIDIR_SEL_POLARITY;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_GAP, S_POST, S_DONE
    } state_t;

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic               acc_idx, nxt_acc;
    logic               req_rs, req_rw, req_nibble, polling;
    logic               nxt_req_rs, nxt_req_rw, nxt_req_nibble, nxt_polling;
    logic [7:0]         req_wdata, nxt_req_wdata, rd_buf, nxt_rd_buf, nxt_rdata;
    logic               nxt_done, nxt_timeout, nxt_lcd_rs, nxt_lcd_rw, nxt_drive;
    logic [7:0]         nxt_lcd_wdata;
    logic               start_acc, end_acc, go_done;
`ifdef LCD_BUSY_POLL_EN
    logic [CNT_W-1:0]   poll_cnt, nxt_poll_cnt;
    logic               bf, nxt_bf;
`endif

    // Next-state and next-output decode; every registered output is loaded from here.
    always_comb begin
        nxt_state      = state;
        nxt_cnt        = cnt + CNT_W'(1);
        nxt_acc        = acc_idx;
        nxt_req_rs     = req_rs;
        nxt_req_rw     = req_rw;
        nxt_req_wdata  = req_wdata;
        nxt_req_nibble = req_nibble;
        nxt_polling    = polling;
        nxt_rd_buf     = rd_buf;
        nxt_rdata      = o_rdata;
        nxt_done       = 1'b0;
        nxt_timeout    = 1'b0;
        nxt_lcd_rs     = o_lcd_rs;
        nxt_lcd_rw     = o_lcd_rw;
        nxt_lcd_wdata  = o_lcd_wdata;
        start_acc      = 1'b0;
        end_acc        = 1'b0;
        go_done        = 1'b0;
`ifdef LCD_BUSY_POLL_EN
        nxt_poll_cnt   = poll_cnt;
        nxt_bf         = bf;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                nxt_state = S_IDLE;
                if (i_start) begin
                    nxt_req_rs     = i_rs;
                    nxt_req_rw     = i_rw;
                    nxt_req_wdata  = i_wdata;
                    nxt_req_nibble = i_nibble;
                    nxt_acc        = 1'b0;
                    nxt_polling    = 1'b0;
                    start_acc      = 1'b1;
                end
            end
            S_SETUP: if (cnt == CNT_W'(N_AS - 1)) nxt_state = S_PULSE;
            S_PULSE: begin
                if (cnt == CNT_W'(N_AS + N_PW - 1)) begin
                    nxt_state = S_HOLD;
                    if (!req_nibble)  nxt_rd_buf      = i_lcd_data;
                    else if (!acc_idx) nxt_rd_buf[7:4] = i_lcd_data[7:4];
                    else              nxt_rd_buf[3:0] = i_lcd_data[7:4];
`ifdef LCD_BUSY_POLL_EN
                    if (!acc_idx) nxt_bf = i_lcd_data[7];
`endif
                end
            end
            S_HOLD: begin
                if (cnt == CNT_W'(N_AS + N_PW + N_H - 1)) begin
                    if (cnt == CNT_W'(N_CYC - 1)) end_acc = 1'b1;
                    else                          nxt_state = S_GAP;
                end
            end
            S_GAP:  if (cnt == CNT_W'(N_CYC - 1)) end_acc = 1'b1;
            S_POST: if (cnt == CNT_W'(N_EXEC - 1)) go_done = 1'b1;
            default: nxt_state = S_IDLE;
        endcase

        // Second nibble, then either the fixed wait or the busy-flag poll loop.
        if (end_acc) begin
            if (req_nibble && !acc_idx) begin
                nxt_acc   = 1'b1;
                start_acc = 1'b1;
            end else begin
`ifdef LCD_BUSY_POLL_EN
                if (req_rw) begin
                    go_done = 1'b1;
                end else if (!polling) begin
                    nxt_polling  = 1'b1;
                    nxt_poll_cnt = '0;
                    nxt_acc      = 1'b0;
                    start_acc    = 1'b1;
                end else if (!bf) begin
                    go_done = 1'b1;
                end else if (poll_cnt == CNT_W'(G_POLL_TIMEOUT - 1)) begin
                    go_done     = 1'b1;
                    nxt_timeout = 1'b1;
                end else begin
                    nxt_poll_cnt = poll_cnt + CNT_W'(1);
                    nxt_acc      = 1'b0;
                    start_acc    = 1'b1;
                end
`else
                nxt_state = S_POST;
                nxt_cnt   = '0;
`endif
            end
        end

        if (start_acc) begin
            nxt_state  = S_SETUP;
            nxt_cnt    = '0;
            nxt_lcd_rs = nxt_req_rs & ~nxt_polling;
            nxt_lcd_rw = nxt_req_rw | nxt_polling;
            if (!nxt_req_nibble) nxt_lcd_wdata = nxt_req_wdata;
            else if (!nxt_acc)   nxt_lcd_wdata = {nxt_req_wdata[7:4], 4'h0};
            else                 nxt_lcd_wdata = {nxt_req_wdata[3:0], 4'h0};
        end

        if (go_done) begin
            nxt_state = S_DONE;
            nxt_done  = 1'b1;
            if (req_rw) nxt_rdata = rd_buf;
        end

        nxt_drive = ((nxt_state == S_SETUP) || (nxt_state == S_PULSE) || (nxt_state == S_HOLD))
                    && !nxt_req_rw && !nxt_polling;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc_idx     <= 1'b0;
            req_rs      <= 1'b0;
            req_rw      <= 1'b1;
            req_wdata   <= '0;
            req_nibble  <= 1'b0;
            polling     <= 1'b0;
            rd_buf      <= '0;
            o_ready     <= 1'b1;
            o_done      <= 1'b0;
            o_rdata     <= '0;
            o_timeout   <= 1'b0;
            o_lcd_rs    <= 1'b0;
            o_lcd_rw    <= 1'b1;
            o_lcd_en    <= 1'b0;
            o_lcd_wdata <= '0;
            o_bidir_sel <= ~BIDIR_DRV;
`ifdef LCD_BUSY_POLL_EN
            poll_cnt    <= '0;
            bf          <= 1'b0;
`endif
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            acc_idx     <= nxt_acc;
            req_rs      <= nxt_req_rs;
            req_rw      <= nxt_req_rw;
            req_wdata   <= nxt_req_wdata;
            req_nibble  <= nxt_req_nibble;
            polling     <= nxt_polling;
            rd_buf      <= nxt_rd_buf;
            o_ready     <= (nxt_state == S_IDLE) || (nxt_state == S_DONE);
            o_done      <= nxt_done;
            o_rdata     <= nxt_rdata;
            o_timeout   <= nxt_timeout;
            o_lcd_rs    <= nxt_lcd_rs;
            o_lcd_rw    <= nxt_lcd_rw;
            o_lcd_en    <= (nxt_state == S_PULSE);
            o_lcd_wdata <= nxt_lcd_wdata;
            o_bidir_sel <= nxt_drive ? BIDIR_DRV : ~BIDIR_DRV;
`ifdef LCD_BUSY_POLL_EN
            poll_cnt    <= nxt_poll_cnt;
            bf          <= nxt_bf;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_cfah_bus_engine.sv
// Directed bench for lcd_cfah_bus_engine at default timing (N_AS=3, N_PW=23, N_H=1, N_CYC=50, N_EXEC=2000).
module tb_lcd_cfah_bus_engine;

`ifdef LCD_BUSY_POLL_EN
    localparam int WR8_TAIL = 50;
    localparam int WRN_TAIL = 100;
    localparam int RD_TAIL  = 0;
`else
    localparam int WR8_TAIL = 2000;
    localparam int WRN_TAIL = 2000;
    localparam int RD_TAIL  = 2000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0, i_rs = 1'b0, i_rw = 1'b0, i_nibble = 1'b0;
    logic [7:0] i_wdata = 8'h00;
    logic       o_ready, o_done, o_timeout, o_lcd_rs, o_lcd_rw, o_lcd_en, o_bidir_sel;
    logic [7:0] o_rdata, o_lcd_wdata, i_lcd_data;
    logic [7:0] emu_data = 8'h00;
    logic       poll_mode = 1'b0;
    int         bf_limit = 0, rd_pulses = 0, rd_base = 0;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    always @(negedge o_lcd_en) if (o_lcd_rw) rd_pulses++;

    assign i_lcd_data = poll_mode ? (((rd_pulses - rd_base) < bf_limit) ? 8'h80 : 8'h00) : emu_data;

    lcd_cfah_bus_engine #(.G_POLL_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_rs(i_rs), .i_rw(i_rw), .i_wdata(i_wdata),
        .i_nibble(i_nibble), .o_ready(o_ready), .o_done(o_done), .o_rdata(o_rdata),
        .o_timeout(o_timeout), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en),
        .o_lcd_wdata(o_lcd_wdata), .i_lcd_data(i_lcd_data), .o_bidir_sel(o_bidir_sel)
    );

    // Raise i_start for exactly one edge; returns 1 ns after that edge (cycle 1 of the request).
    task automatic start_req(input logic rs, input logic rw, input logic [7:0] wd, input logic nib);
        i_rs = rs; i_rw = rw; i_wdata = wd; i_nibble = nib; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // Observe the bus cycle by cycle until o_done or max_cyc.
    task automatic watch(input int start_cyc, input int max_cyc, input logic [7:0] d0, input logic [7:0] d1,
                         output int rise0, output int rise1, output int rises, output int en_wr,
                         output int bidir_cnt, output logic [7:0] wd0, output logic [7:0] wd1,
                         output int done_cyc, output logic tmo, output logic [7:0] rd);
        int cyc;
        logic prev_en;
        cyc = start_cyc; prev_en = 1'b0;
        rise0 = -1; rise1 = -1; rises = 0; en_wr = 0; bidir_cnt = 0;
        wd0 = 8'h00; wd1 = 8'h00; done_cyc = 0; tmo = 1'b0; rd = 8'h00;
        emu_data = d0;
        forever begin
            if (o_lcd_en && !prev_en) begin
                if (rises == 0) begin rise0 = cyc; wd0 = o_lcd_wdata; end
                else if (rises == 1) begin rise1 = cyc; wd1 = o_lcd_wdata; end
                rises++;
            end
            if (!o_lcd_en && rises >= 1) emu_data = d1;
            if (o_lcd_en && !o_lcd_rw) en_wr++;
            if (o_bidir_sel) bidir_cnt++;
            prev_en = o_lcd_en;
            if (o_done) begin done_cyc = cyc; tmo = o_timeout; rd = o_rdata; break; end
            if (cyc >= max_cyc) break;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        checks++; if (o_done !== 1'b0 || o_timeout !== 1'b0) begin failures++; $display("FAIL reset_done got=%b%b exp=00", o_done, o_timeout); end
        checks++; if (o_rdata !== 8'h00 || o_lcd_wdata !== 8'h00) begin failures++; $display("FAIL reset_data got=%h/%h exp=00/00", o_rdata, o_lcd_wdata); end
        checks++; if ({o_lcd_en, o_lcd_rs, o_lcd_rw, o_bidir_sel} !== 4'b0010) begin failures++; $display("FAIL reset_pins got=%b exp=0010", {o_lcd_en, o_lcd_rs, o_lcd_rw, o_bidir_sel}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write8();
        int r0, r1, n, ew, bd, dc; logic [7:0] w0, w1, rd; logic tm;
        start_req(1'b1, 1'b0, 8'h41, 1'b0);
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL w8_ready_drop got=%b exp=0", o_ready); end
        checks++; if ({o_lcd_rs, o_lcd_rw, o_lcd_en} !== 3'b100) begin failures++; $display("FAIL w8_setup_pins got=%b exp=100", {o_lcd_rs, o_lcd_rw, o_lcd_en}); end
        watch(1, 2300, 8'h00, 8'h00, r0, r1, n, ew, bd, w0, w1, dc, tm, rd);
        checks++; if (r0 !== 4) begin failures++; $display("FAIL w8_en_rise got=%0d exp=4", r0); end
        checks++; if (ew !== 23) begin failures++; $display("FAIL w8_en_width got=%0d exp=23", ew); end
        checks++; if (w0 !== 8'h41) begin failures++; $display("FAIL w8_wdata got=%h exp=41", w0); end
        checks++; if (bd !== 27) begin failures++; $display("FAIL w8_bidir_cycles got=%0d exp=27", bd); end
        checks++; if (dc !== 1 + 50 + WR8_TAIL) begin failures++; $display("FAIL w8_latency got=%0d exp=%0d", dc, 1 + 50 + WR8_TAIL); end
        checks++; if (o_ready !== 1'b1 || tm !== 1'b0) begin failures++; $display("FAIL w8_done_ready got=%b tmo=%b exp=1/0", o_ready, tm); end
        @(posedge clk); #1;
        checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL w8_done_pulse got=%b exp=0", o_done); end
    endtask

    task automatic test_nibble_write();
        int r0, r1, n, ew, bd, dc; logic [7:0] w0, w1, rd; logic tm;
        start_req(1'b0, 1'b0, 8'hA5, 1'b1);
        watch(1, 2400, 8'h00, 8'h00, r0, r1, n, ew, bd, w0, w1, dc, tm, rd);
        checks++; if (r0 !== 4 || r1 !== 54) begin failures++; $display("FAIL nw_en_rises got=%0d,%0d exp=4,54", r0, r1); end
        checks++; if (w0 !== 8'hA0 || w1 !== 8'h50) begin failures++; $display("FAIL nw_wdata got=%h,%h exp=a0,50", w0, w1); end
        checks++; if (ew !== 46) begin failures++; $display("FAIL nw_en_width got=%0d exp=46", ew); end
        checks++; if (bd !== 54) begin failures++; $display("FAIL nw_bidir_cycles got=%0d exp=54", bd); end
        checks++; if (dc !== 1 + 100 + WRN_TAIL) begin failures++; $display("FAIL nw_latency got=%0d exp=%0d", dc, 1 + 100 + WRN_TAIL); end
    endtask

    task automatic test_read();
        int r0, r1, n, ew, bd, dc; logic [7:0] w0, w1, rd; logic tm;
        start_req(1'b1, 1'b1, 8'hFF, 1'b0);
        checks++; if ({o_lcd_rs, o_lcd_rw} !== 2'b11) begin failures++; $display("FAIL rd_pins got=%b exp=11", {o_lcd_rs, o_lcd_rw}); end
        watch(1, 2300, 8'h3C, 8'hC3, r0, r1, n, ew, bd, w0, w1, dc, tm, rd);
        checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL rd_data got=%h exp=3c", rd); end
        checks++; if (bd !== 0) begin failures++; $display("FAIL rd_bidir_cycles got=%0d exp=0", bd); end
        checks++; if (r0 !== 4) begin failures++; $display("FAIL rd_en_rise got=%0d exp=4", r0); end
        checks++; if (dc !== 1 + 50 + RD_TAIL) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", dc, 1 + 50 + RD_TAIL); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_rdata !== 8'h3C) begin failures++; $display("FAIL rd_hold got=%h exp=3c", o_rdata); end
    endtask

    task automatic test_nibble_read();
        int r0, r1, n, ew, bd, dc; logic [7:0] w0, w1, rd; logic tm;
        start_req(1'b0, 1'b1, 8'h00, 1'b1);
        watch(1, 2400, 8'h7A, 8'h95, r0, r1, n, ew, bd, w0, w1, dc, tm, rd);
        checks++; if (rd !== 8'h79) begin failures++; $display("FAIL nr_data got=%h exp=79", rd); end
        checks++; if (dc !== 1 + 100 + RD_TAIL) begin failures++; $display("FAIL nr_latency got=%0d exp=%0d", dc, 1 + 100 + RD_TAIL); end
    endtask

    task automatic test_reset_mid();
        int r0, r1, n, ew, bd, dc; logic [7:0] w0, w1, rd; logic tm;
        start_req(1'b1, 1'b0, 8'h77, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        checks++; if (o_lcd_en !== 1'b1) begin failures++; $display("FAIL rm_in_pulse got=%b exp=1", o_lcd_en); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({o_lcd_en, o_ready, o_bidir_sel, o_done} !== 4'b0100) begin failures++; $display("FAIL rm_after_rst got=%b exp=0100", {o_lcd_en, o_ready, o_bidir_sel, o_done}); end
        watch(0, 100, 8'h00, 8'h00, r0, r1, n, ew, bd, w0, w1, dc, tm, rd);
        checks++; if (n !== 0 || dc !== 0) begin failures++; $display("FAIL rm_dropped got=rises %0d done %0d exp=0,0", n, dc); end
    endtask

    task automatic test_back_to_back();
        int r0, r1, n, ew, bd, dc; logic [7:0] w0, w1, rd; logic tm;
        start_req(1'b0, 1'b0, 8'h12, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        i_rs = 1'b1; i_rw = 1'b1; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        checks++; if ({o_lcd_rs, o_lcd_rw, o_ready} !== 3'b000) begin failures++; $display("FAIL busy_ignored got=%b exp=000", {o_lcd_rs, o_lcd_rw, o_ready}); end
        watch(11, 2300, 8'h00, 8'h00, r0, r1, n, ew, bd, w0, w1, dc, tm, rd);
        checks++; if (dc !== 1 + 50 + WR8_TAIL || w0 !== 8'h12) begin failures++; $display("FAIL busy_txn got=%0d/%h exp=%0d/12", dc, w0, 1 + 50 + WR8_TAIL); end
        start_req(1'b1, 1'b1, 8'h00, 1'b0);
        checks++; if ({o_ready, o_lcd_rs, o_lcd_rw, o_done} !== 4'b0110) begin failures++; $display("FAIL b2b_setup got=%b exp=0110", {o_ready, o_lcd_rs, o_lcd_rw, o_done}); end
        watch(1, 2300, 8'h5A, 8'h00, r0, r1, n, ew, bd, w0, w1, dc, tm, rd);
        checks++; if (r0 !== 4 || rd !== 8'h5A) begin failures++; $display("FAIL b2b_read got=%0d/%h exp=4/5a", r0, rd); end
        checks++; if (dc !== 1 + 50 + RD_TAIL) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", dc, 1 + 50 + RD_TAIL); end
    endtask

`ifdef LCD_BUSY_POLL_EN
    task automatic test_poll();
        int r0, r1, n, ew, bd, dc; logic [7:0] w0, w1, rd; logic tm;
        poll_mode = 1'b1; bf_limit = 3; rd_base = rd_pulses;
        start_req(1'b0, 1'b0, 8'h01, 1'b0);
        watch(1, 1000, 8'h00, 8'h00, r0, r1, n, ew, bd, w0, w1, dc, tm, rd);
        checks++; if (n !== 5 || dc !== 251 || tm !== 1'b0) begin failures++; $display("FAIL poll_clear got=%0d/%0d/%b exp=5/251/0", n, dc, tm); end
        @(posedge clk); #1;
        bf_limit = 1000; rd_base = rd_pulses;
        start_req(1'b0, 1'b0, 8'h01, 1'b0);
        watch(1, 1000, 8'h00, 8'h00, r0, r1, n, ew, bd, w0, w1, dc, tm, rd);
        checks++; if (n !== 5 || dc !== 251 || tm !== 1'b1) begin failures++; $display("FAIL poll_timeout got=%0d/%0d/%b exp=5/251/1", n, dc, tm); end
        poll_mode = 1'b0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_write8();
        test_nibble_write();
        test_read();
        test_nibble_read();
        test_reset_mid();
        test_back_to_back();
`ifdef LCD_BUSY_POLL_EN
        test_poll();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
